// File: rtl/adc_sample_packer_if.sv
// Sample-stream and FIFO write-port bundles used by adc_sample_packer.
// The stream side has no backpressure, and the FIFO side reports full only.
interface adc_sample_if;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_first;
  logic        s_last;

  modport master (output s_tdata, s_tvalid, s_first, s_last);
  modport slave  (input  s_tdata, s_tvalid, s_first, s_last);
endinterface

interface adc_fifo_wr_if #(parameter int DATA_WIDTH = 512);
  logic                  m_wr_en;
  logic [DATA_WIDTH-1:0] m_wr_data;
  logic                  m_fifo_full;

  modport master (output m_wr_en, m_wr_data, input m_fifo_full);
  modport slave  (input m_wr_en, m_wr_data, output m_fifo_full);
endinterface

// File: rtl/adc_sample_packer.sv
// Packs 64-bit samples into DATA_WIDTH-bit FIFO words, framing each capture with a header and a trailer.
// The stream cannot stall, so a write that meets a full FIFO is dropped and counted.
module adc_sample_packer #(
  parameter int          DATA_WIDTH    = 512,
  parameter logic [63:0] PAD_WORD      = 64'h0,
  parameter logic [31:0] HEADER_MAGIC  = 32'hC1A5_0001,
  parameter logic [31:0] TRAILER_MAGIC = 32'hC1A5_00FF
) (
  input  logic                 clk_245,
  input  logic                 clk_245_rst,
  adc_sample_if.slave          smp,
  adc_fifo_wr_if.master        fifo,
  input  logic [63:0]          timestamp,
  output logic                 busy,
  output logic                 overflow,
  output logic                 protocol_err,
  output logic [31:0]          capture_seq
);

  localparam int             LANES    = DATA_WIDTH / 64;
  localparam int             PW       = $clog2(LANES);
  localparam logic [PW-1:0]  TOP_LANE = PW'(LANES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PACK = 2'd1, FLUSH = 2'd2, TRAIL = 2'd3} state_t;

  state_t                state_r, state_next_s;
  logic [PW-1:0]         lane_r;
  logic [DATA_WIDTH-1:0] buf_r, wr_data_r;
  logic [63:0]           ts_r;
  logic [31:0]           count_r, dropped_r, seq_r;
  logic                  wr_en_r, busy_r, overflow_r, proto_r;

  logic [DATA_WIDTH-1:0] word_pack_s, word_flush_s, wr_word_s;
  logic                  wr_req_s, drop_s, start_s;

  function automatic logic [DATA_WIDTH-1:0] build_header(input logic [63:0] ts, input logic [31:0] seq);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-1 -: 128] = {ts, seq, HEADER_MAGIC};
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] build_trailer(input logic [63:0] ts, input logic [31:0] seq,
                                                          input logic [31:0] cnt, input logic [31:0] drp);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-1 -: 192] = {ts, seq, TRAILER_MAGIC, cnt, drp};
    return w;
  endfunction

  assign start_s = smp.s_tvalid && smp.s_first;
  assign drop_s  = wr_req_s && fifo.m_fifo_full;

  // Lanes above the pointer hold earlier samples; the pointer lane takes the new sample; lower lanes pad.
  always_comb begin
    word_pack_s  = '0;
    word_flush_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (PW'(i) > lane_r) begin
        word_pack_s[i*64 +: 64]  = buf_r[i*64 +: 64];
        word_flush_s[i*64 +: 64] = buf_r[i*64 +: 64];
      end else if (PW'(i) == lane_r) begin
        word_pack_s[i*64 +: 64]  = smp.s_tdata;
        word_flush_s[i*64 +: 64] = PAD_WORD;
      end else begin
        word_pack_s[i*64 +: 64]  = PAD_WORD;
        word_flush_s[i*64 +: 64] = PAD_WORD;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_245 or posedge clk_245_rst) begin
    if (clk_245_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and the write request launched this cycle.
  always_comb begin
    state_next_s = state_r;
    wr_req_s     = 1'b0;
    wr_word_s    = '0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          wr_req_s     = 1'b1;
          wr_word_s    = build_header(timestamp, seq_r);
          state_next_s = smp.s_last ? FLUSH : PACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      PACK: begin
        if (smp.s_tvalid && (smp.s_last || (lane_r == '0))) begin
          wr_req_s     = 1'b1;
          wr_word_s    = word_pack_s;
          state_next_s = smp.s_last ? TRAIL : PACK;
        end else begin
          state_next_s = PACK;
        end
      end
      FLUSH: begin
        wr_req_s     = 1'b1;
        wr_word_s    = word_flush_s;
        state_next_s = TRAIL;
      end
      TRAIL: begin
        wr_req_s     = 1'b1;
        wr_word_s    = build_trailer(ts_r, seq_r, count_r, dropped_r);
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath, metadata counters and registered outputs.
  always_ff @(posedge clk_245 or posedge clk_245_rst) begin
    if (clk_245_rst) begin
      lane_r     <= TOP_LANE;
      buf_r      <= '0;
      wr_data_r  <= '0;
      ts_r       <= 64'd0;
      count_r    <= 32'd0;
      dropped_r  <= 32'd0;
      seq_r      <= 32'd0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      proto_r    <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      if (wr_req_s && !fifo.m_fifo_full) begin
        wr_en_r   <= 1'b1;
        wr_data_r <= wr_word_s;
      end else begin
        wr_en_r <= 1'b0;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (start_s && (state_r != IDLE)) begin
        proto_r <= 1'b1;
      end
      // A header dropped at capture start is already the first dropped word.
      if (state_r == IDLE) begin
        if (start_s) begin
          dropped_r <= {31'd0, fifo.m_fifo_full};
        end
      end else if (drop_s && (dropped_r != 32'hFFFF_FFFF)) begin
        dropped_r <= dropped_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            buf_r[DATA_WIDTH-1 -: 64] <= smp.s_tdata;
            ts_r    <= timestamp;
            count_r <= 32'd1;
            lane_r  <= TOP_LANE - PW'(1);
          end
        end
        PACK: begin
          if (smp.s_tvalid) begin
            buf_r   <= word_pack_s;
            count_r <= count_r + 32'd1;
            lane_r  <= (smp.s_last || (lane_r == '0)) ? TOP_LANE : (lane_r - PW'(1));
            if (smp.s_last) begin
              ts_r <= timestamp;
            end
          end
        end
        FLUSH: begin
          lane_r <= TOP_LANE;
        end
        TRAIL: begin
          lane_r <= TOP_LANE;
          seq_r  <= seq_r + 32'd1;
        end
        default: begin
          lane_r <= TOP_LANE;
        end
      endcase
    end
  end

  assign fifo.m_wr_en   = wr_en_r;
  assign fifo.m_wr_data = wr_data_r;
  assign busy           = busy_r;
  assign overflow       = overflow_r;
  assign protocol_err   = proto_r;
  assign capture_seq    = seq_r;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer with DATA_WIDTH=512 (8 lanes) and PAD_WORD=0.
module tb_adc_sample_packer;

  localparam logic [31:0] HMAGIC = 32'hC1A5_0001;
  localparam logic [31:0] TMAGIC = 32'hC1A5_00FF;
  localparam logic [63:0] PAD    = 64'h0;

  logic        clk_245;
  logic        clk_245_rst;
  logic [63:0] timestamp;
  logic        busy, overflow, protocol_err;
  logic [31:0] capture_seq;

  adc_sample_if smp();
  adc_fifo_wr_if #(.DATA_WIDTH(512)) fifo();

  adc_sample_packer #(.DATA_WIDTH(512)) dut (
    .clk_245      (clk_245),
    .clk_245_rst  (clk_245_rst),
    .smp          (smp),
    .fifo         (fifo),
    .timestamp    (timestamp),
    .busy         (busy),
    .overflow     (overflow),
    .protocol_err (protocol_err),
    .capture_seq  (capture_seq)
  );

  initial clk_245 = 1'b0;
  always #5 clk_245 = ~clk_245;

  int           tests = 0;
  int           fails = 0;
  int           cyc_n = 0;
  logic [511:0] last_wr = '0;
  logic [63:0]  ts_s;

  function automatic logic [511:0] hdr(input logic [63:0] ts, input logic [31:0] seq);
    return {ts, seq, HMAGIC, 384'h0};
  endfunction

  function automatic logic [511:0] trl(input logic [63:0] ts, input logic [31:0] seq,
                                       input logic [31:0] cnt, input logic [31:0] drp);
    return {ts, seq, TMAGIC, cnt, drp, 320'h0};
  endfunction

  // Top lane holds the earliest sample; unfilled lanes carry PAD.
  function automatic logic [511:0] mk(input int v0, input int nv);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      w[511 - 64*k -: 64] = (k < nv) ? 64'(v0 + k) : PAD;
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input logic [63:0] d, input logic full);
    smp.s_tvalid     = v;
    smp.s_first      = f;
    smp.s_last       = l;
    smp.s_tdata      = d;
    fifo.m_fifo_full = full;
    timestamp        = 64'h7100_0000_0000_0000 + 64'(cyc_n);
    cyc_n++;
    @(posedge clk_245);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [511:0] data);
    check({tag, "_en"}, 512'(fifo.m_wr_en), 512'(en));
    if (en) begin
      check({tag, "_data"}, fifo.m_wr_data, data);
      last_wr = data;
    end else begin
      check({tag, "_hold"}, fifo.m_wr_data, last_wr);
    end
  endtask

  // One capture of n samples valued v0.. ; optional full on sample full_i, extra s_first on first2_i,
  // and an s_first presented in the trailer cycle when trail_first is set.
  task automatic capture(input string tag, input int n, input int v0, input int full_i, input int first2_i,
                         input logic trail_first, input logic [31:0] seq, input logic [31:0] drop);
    logic [63:0] ts_f, ts_l;
    ts_f = '0;
    ts_l = '0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i == 0) || (i == first2_i), i == n - 1, 64'(v0 + i), i == full_i);
      if (i == 0) ts_f = timestamp;
      if (i == n - 1) ts_l = timestamp;
      if (i == 0) begin
        expect_wr({tag, "_hdr"}, 1'b1, hdr(ts_f, seq));
      end else if ((i == n - 1) || ((i % 8) == 7)) begin
        expect_wr({tag, "_word"}, i != full_i, mk(v0 + (i / 8) * 8, (i % 8) + 1));
      end else begin
        expect_wr({tag, "_gap"}, 1'b0, '0);
      end
    end
    drive(trail_first, trail_first, 1'b0, 64'hDEAD, 1'b0);
    expect_wr({tag, "_trl"}, 1'b1, trl(ts_l, seq, 32'(n), drop));
    check({tag, "_seq"}, 512'(capture_seq), 512'(seq + 32'd1));
    check({tag, "_busy"}, 512'(busy), 512'(0));
  endtask

  initial begin
    clk_245_rst      = 1'b1;
    smp.s_tvalid     = 1'b0;
    smp.s_first      = 1'b0;
    smp.s_last       = 1'b0;
    smp.s_tdata      = 64'h0;
    fifo.m_fifo_full = 1'b0;
    timestamp        = 64'h0;
    repeat (3) @(posedge clk_245);
    #1;
    check("rst_wr_en", 512'(fifo.m_wr_en), 512'(0));
    check("rst_wr_data", fifo.m_wr_data, 512'h0);
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_overflow", 512'(overflow), 512'(0));
    check("rst_proto", 512'(protocol_err), 512'(0));
    check("rst_seq", 512'(capture_seq), 512'(0));
    clk_245_rst = 1'b0;

    // Non-first samples in IDLE are ignored.
    drive(1'b1, 1'b0, 1'b0, 64'h77, 1'b0);
    expect_wr("idle_discard", 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 64'h78, 1'b0);
    expect_wr("idle_discard_last", 1'b0, '0);
    check("idle_busy", 512'(busy), 512'(0));

    capture("cap16", 16, 1, -1, -1, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    expect_wr("cap16_after", 1'b0, '0);

    capture("cap11", 11, 1, -1, -1, 1'b0, 32'd1, 32'd0);
    check("pre_full_overflow", 512'(overflow), 512'(0));

    capture("full", 16, 101, 15, -1, 1'b0, 32'd2, 32'd1);
    check("full_overflow", 512'(overflow), 512'(1));

    // First and last on the same sample.
    drive(1'b1, 1'b1, 1'b1, 64'h55, 1'b0);
    ts_s = timestamp;
    expect_wr("single_hdr", 1'b1, hdr(ts_s, 32'd3));
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    expect_wr("single_word", 1'b1, mk(85, 1));
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    expect_wr("single_trl", 1'b1, trl(ts_s, 32'd3, 32'd1, 32'd0));
    check("single_seq", 512'(capture_seq), 512'(4));
    check("pre_mid_proto", 512'(protocol_err), 512'(0));

    capture("midfirst", 12, 201, -1, 4, 1'b0, 32'd4, 32'd0);
    check("midfirst_proto", 512'(protocol_err), 512'(1));

    capture("b2bA", 8, 301, -1, -1, 1'b1, 32'd5, 32'd0);
    capture("b2bB", 10, 401, -1, -1, 1'b0, 32'd6, 32'd0);

    // Reset in the middle of a capture.
    drive(1'b1, 1'b1, 1'b0, 64'd501, 1'b0);
    expect_wr("mrst_hdr", 1'b1, hdr(timestamp, 32'd7));
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 64'(501 + i), 1'b0);
    end
    check("mrst_busy_before", 512'(busy), 512'(1));
    clk_245_rst = 1'b1;
    #2;
    check("mrst_wr_en", 512'(fifo.m_wr_en), 512'(0));
    check("mrst_wr_data", fifo.m_wr_data, 512'h0);
    check("mrst_busy", 512'(busy), 512'(0));
    check("mrst_overflow", 512'(overflow), 512'(0));
    check("mrst_proto", 512'(protocol_err), 512'(0));
    check("mrst_seq", 512'(capture_seq), 512'(0));
    @(posedge clk_245);
    #1;
    clk_245_rst = 1'b0;
    last_wr = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      expect_wr("mrst_no_trl", 1'b0, '0);
    end
    capture("post_rst", 8, 601, -1, -1, 1'b0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
